// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//
// Execute stage that sits between the register-file read ports and the
// register-file write port. On an issue strobe in IDLE it captures the opcode,
// destination and operands (B or the immediate). It computes an 8-bit result
// and presents it to the register file for exactly one cycle in WB.
//
// Optional feature macro: ALU_MUL_EN
//   defined   : op 8 is an unsigned shift-add multiply (low byte of A*B),
//               one multiplier bit per cycle for MUL_CYCLES cycles.
//   undefined : no multiply datapath, counter or MUL state exists; op 8 is
//               treated as a NOP (two-cycle latency, no write, flags kept).
//
// Ports
//   clk       in   1  system clock, all state changes on the rising edge
//   rst       in   1  synchronous active-high reset
//   start     in   1  issue strobe, only looked at in IDLE
//   op        in   4  opcode, captured with start
//   dst_addr  in   3  destination register, captured with start
//   a_data    in   8  operand A (register-file port A)
//   b_data    in   8  operand B (register-file port B)
//   imm       in   8  immediate operand
//   use_imm   in   1  1: operand B is imm, 0: operand B is b_data
//   busy      out  1  high in every state except IDLE
//   done      out  1  one-cycle pulse in WB
//   RW        out  1  register-file write enable, WB only, writing ops only
//   d_addr    out  3  register-file write address (holds outside WB)
//   wb_data   out  8  register-file write data (holds outside WB)
//   flags     out  4  status {Z, N, C, V}
// -----------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int MUL_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [2:0] dst_addr,
  input  logic [7:0] a_data,
  input  logic [7:0] b_data,
  input  logic [7:0] imm,
  input  logic       use_imm,
  output logic       busy,
  output logic       done,
  output logic       RW,
  output logic [2:0] d_addr,
  output logic [7:0] wb_data,
  output logic [3:0] flags
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
`ifdef ALU_MUL_EN
    ,
    S_MUL  = 2'd3
`endif
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [3:0] op_q;
  logic [2:0] dst_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] b_mux;
  logic       issue;
  logic       op_writes;

  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] alu_res;
  logic       alu_c;
  logic       alu_v;

  assign b_mux = use_imm ? imm : b_data;
  assign issue = (state == S_IDLE) && start;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

`ifdef ALU_MUL_EN
  // ---------------------------------------------------------------------------
  // Shift-add multiplier: one multiplier bit per MUL cycle. The multiplicand
  // shifts left while the multiplier shifts right, so bit 0 always selects.
  // ---------------------------------------------------------------------------
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  logic [15:0]      mul_acc;
  logic [15:0]      mul_mcand;
  logic [7:0]       mul_mplier;
  logic [CNT_W-1:0] mul_cnt;

  // NOTE: datapath registers carry no reset; they are fully reloaded on every
  // issue and are never observed before that, so a reset would only add
  // routing on wide buses. Only control state and visible outputs reset.
  always_ff @(posedge clk) begin
    if (issue) begin
      mul_acc    <= '0;
      mul_mcand  <= {8'h00, a_data};
      mul_mplier <= b_mux;
      mul_cnt    <= '0;
    end else if (state == S_MUL) begin
      if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + 1'b1;
    end
  end
`else
  // The parameter only sizes the multiplier; keep it referenced so both
  // builds present the same parameter list.
  logic unused_mul_cfg;
  assign unused_mul_cfg = (MUL_CYCLES == 8);
`endif

  // ---------------------------------------------------------------------------
  // Next-state and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every variable written in an always_comb gets a default at the top,
  // so no path through the case statement can leave it unassigned (latch).
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_WB);
    RW        = (state == S_WB) && op_writes;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_MUL_EN
          state_nxt = (op == OP_MUL) ? S_MUL : S_EXEC;
`else
          state_nxt = S_EXEC;
`endif
        end
      end
      S_EXEC: state_nxt = S_WB;
`ifdef ALU_MUL_EN
      // After the last iteration the product is folded into the result
      // registers by one EXEC cycle, exactly like the single-cycle ops.
      S_MUL: if (mul_cnt == CNT_LAST) state_nxt = S_EXEC;
`endif
      // Start is not sampled here: an issue during WB is dropped.
      S_WB:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture (operands are don't-care after the issue cycle)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (issue) begin
      op_q  <= op;
      dst_q <= dst_addr;
      a_q   <= a_data;
      b_q   <= b_mux;
    end
  end

`ifdef ALU_MUL_EN
  assign op_writes = (op_q <= OP_MOV);
`else
  assign op_writes = (op_q <= OP_MOV) && (op_q != OP_MUL);
`endif

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  assign sum9  = {1'b0, a_q} + {1'b0, b_q};
  // Bit 8 of the 9-bit difference is the unsigned borrow (A < B).
  assign diff9 = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum9[7:0];
        alu_c   = sum9[8];
        // Overflow: operands share a sign that the result does not.
        alu_v   = (a_q[7] == b_q[7]) && (sum9[7] != a_q[7]);
      end
      OP_SUB: begin
        alu_res = diff9[7:0];
        alu_c   = diff9[8];
        // Overflow: operand signs differ and the result left A's sign.
        alu_v   = (a_q[7] != b_q[7]) && (diff9[7] != a_q[7]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: begin
        alu_res = {a_q[6:0], 1'b0};
        alu_c   = a_q[7];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_q[7:1]};
        alu_c   = a_q[0];
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        alu_res = mul_acc[7:0];
        alu_c   = |mul_acc[15:8];
      end
`endif
      OP_MOV: alu_res = b_q;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write-back registers: loaded on the EXEC->WB edge so they are valid for
  // the whole WB cycle, then held. NOPs keep wb_data and flags.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      d_addr  <= '0;
      wb_data <= '0;
      flags   <= '0;
    end else if (state == S_EXEC) begin
      d_addr <= dst_q;
      if (op_writes) begin
        wb_data <= alu_res;
        flags   <= {(alu_res == 8'h00), alu_res[7], alu_c, alu_v};
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
//
// Directed bench for alu_exec_stage. Expected write-back records are pushed to
// a scoreboard queue at issue and popped when done is seen. Works with and
// without ALU_MUL_EN.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

  localparam int MUL_CYCLES = 8;
  localparam int WAIT_MAX   = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] op;
  logic [2:0] dst_addr;
  logic [7:0] a_data;
  logic [7:0] b_data;
  logic [7:0] imm;
  logic       use_imm;
  logic       busy;
  logic       done;
  logic       RW;
  logic [2:0] d_addr;
  logic [7:0] wb_data;
  logic [3:0] flags;

  alu_exec_stage #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dst_addr (dst_addr),
    .a_data   (a_data),
    .b_data   (b_data),
    .imm      (imm),
    .use_imm  (use_imm),
    .busy     (busy),
    .done     (done),
    .RW       (RW),
    .d_addr   (d_addr),
    .wb_data  (wb_data),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw;
    logic [2:0] addr;
    logic [7:0] data;
    logic [3:0] flg;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model_flags;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_stray  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model written from the opcode table with integer arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [2:0] dst,
                                 input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua = a;
    int ub = b;
    int sa = $signed(a);
    int sb_ = $signed(b);
    int full;
    logic [7:0] r = 8'h00;
    logic c = 1'b0;
    logic v = 1'b0;
    bit wr = 1'b1;
    case (o)
      4'd0: begin full = ua + ub; r = full[7:0]; c = (full > 255);
                  v = ((sa + sb_) > 127) || ((sa + sb_) < -128); end
      4'd1: begin full = ua - ub; r = full[7:0]; c = (ua < ub);
                  v = ((sa - sb_) > 127) || ((sa - sb_) < -128); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin r = a << 1; c = a[7]; end
      4'd7: begin r = a >> 1; c = a[0]; end
`ifdef ALU_MUL_EN
      4'd8: begin full = ua * ub; r = full[7:0]; c = (full > 255); end
`endif
      4'd9: r = b;
      default: wr = 1'b0;
    endcase
    e.rw   = wr;
    e.addr = dst;
    e.data = r;
    e.flg  = wr ? {(r == 8'h00), r[7], c, v} : model_flags;
`ifdef ALU_MUL_EN
    e.lat  = (o == 4'd8) ? MUL_CYCLES + 2 : 2;
`else
    e.lat  = 2;
`endif
    return e;
  endfunction

  // Issue one op, wait for WB, compare against the scoreboard.
  // pulse_at: step count at which a stray start is pulsed (-1: none).
  // hold_wb : keep start high during the WB cycle (must be ignored).
  task automatic run_op(input logic [3:0] o, input logic [2:0] dst,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] im, input logic ui,
                        input int pulse_at, input bit hold_wb);
    exp_t e;
    int   lat;
    e = model(o, dst, a, ui ? im : b);
    sb.push_back(e);
    model_flags = e.flg;
    op = o; dst_addr = dst; a_data = a; b_data = b; imm = im; use_imm = ui;
    start = 1'b1;
    step();
    start = 1'b0;
    op = 4'($urandom); dst_addr = 3'($urandom);
    a_data = 8'($urandom); b_data = 8'($urandom); imm = 8'($urandom);
    use_imm = 1'($urandom);
    for (lat = 1; lat < WAIT_MAX && !done; lat++) begin
      if (RW) n_stray++;
      if (lat == pulse_at) begin
        op = 4'd0;
        start = 1'b1;
      end
      step();
      start = 1'b0;
    end
    check("latency", lat, e.lat);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("wb_busy", busy, 1'b1);
      check("wb_rw", RW, e.rw);
      check("wb_addr", d_addr, e.addr);
      if (e.rw) check("wb_data", wb_data, e.data);
      check("wb_flags", flags, e.flg);
    end
    if (hold_wb) begin
      op = 4'd0;
      start = 1'b1;
    end
    step();
    start = 1'b0;
    check("after_wb", {done, RW, busy}, 3'b000);
    if (pulse_at >= 0 || hold_wb) begin
      step();
      check("not_queued", {done, RW, busy}, 3'b000);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ro;
    int         rst_at;

    // Reset, with start asserted to show reset dominates.
    rst = 1'b1; start = 1'b1; op = 4'd0; dst_addr = 3'd0;
    a_data = 8'h00; b_data = 8'h00; imm = 8'h00; use_imm = 1'b0;
    model_flags = 4'h0;
    step();
    step();
    check("reset_state", {busy, done, RW, d_addr, wb_data, flags}, 19'h0);
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle", {busy, done, RW, flags}, 7'h00);
    end

    // ADD with signed overflow: 0x7F + 0x01 = 0x80, Z0 N1 C0 V1.
    run_op(4'd0, 3'd3, 8'h7F, 8'h01, 8'h00, 1'b0, -1, 1'b0);
    check("add_flags_plan", flags, 4'b0101);

    // SUB via immediate: equal operands and then a borrow.
    run_op(4'd1, 3'd2, 8'h05, 8'hAA, 8'h05, 1'b1, -1, 1'b0);
    check("sub_zero_plan", {wb_data, flags}, {8'h00, 4'b1000});
    run_op(4'd1, 3'd2, 8'h03, 8'hAA, 8'h05, 1'b1, -1, 1'b1);
    check("sub_borrow_plan", {wb_data, flags}, {8'hFE, 4'b0110});

    // MUL 0x10*0x20 (or NOP without the multiplier), stray start mid-op.
    run_op(4'd8, 3'd4, 8'h10, 8'h20, 8'h00, 1'b0, 4, 1'b0);
`ifdef ALU_MUL_EN
    check("mul_plan", {wb_data, flags}, {8'h00, 4'b1010});
`else
    check("mul_as_nop_flags", flags, 4'b0110);
`endif
    check("no_stray_write", n_stray, 0);

    // Reset during an op: abandoned, no write.
`ifdef ALU_MUL_EN
    ro = 4'd8; rst_at = 4;
`else
    ro = 4'd0; rst_at = 0;
`endif
    op = ro; dst_addr = 3'd6; a_data = 8'h33; b_data = 8'h07; use_imm = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < rst_at; k++) begin
      if (RW || done) n_stray++;
      step();
    end
    rst = 1'b1;
    step();
    check("rst_mid_op", {busy, done, RW, d_addr, wb_data, flags}, 19'h0);
    rst = 1'b0;
    model_flags = 4'h0;
    check("rst_no_write", n_stray, 0);
    run_op(4'd0, 3'd1, 8'h01, 8'h02, 8'h00, 1'b0, -1, 1'b0);
    check("add_after_rst", wb_data, 8'h03);

    // NOP keeps flags preset by SHL 0x80 (result 0, carry out).
    run_op(4'd6, 3'd7, 8'h80, 8'h00, 8'h00, 1'b0, -1, 1'b0);
    run_op(4'd12, 3'd5, 8'h12, 8'h34, 8'h00, 1'b0, -1, 1'b0);
    check("nop_flags_plan", {RW, flags}, {1'b0, 4'b1010});

    // Sweep every opcode, then random operands and opcodes.
    for (int i = 0; i < 16; i++)
      run_op(4'(i), 3'(i), 8'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom), -1, 1'b0);
    for (int i = 0; i < 12; i++)
      run_op(4'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 1'($urandom), -1, 1'b0);
    check("final_no_stray", n_stray, 0);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
